// File: rtl/up16_pkg.sv
// uP16 shared definitions: field layout, opcodes, ALU codes and the ID/EX payload.
package up16_pkg;

  localparam int unsigned ISIZE   = 18;
  localparam int unsigned DSIZE   = 16;
  localparam int unsigned RSIZE   = 3;
  localparam int unsigned NREGS   = 8;
  localparam int unsigned OPW     = 4;
  localparam int unsigned ALUW    = 3;
  localparam int unsigned IMM_W   = 8;
  localparam int unsigned JMP_W   = 14;

  // Instruction field positions (LSB of each field)
  localparam int unsigned OP_LSB  = 14;
  localparam int unsigned RD_LSB  = 11;
  localparam int unsigned RS1_LSB = 8;
  localparam int unsigned RS2_LSB = 5;

  localparam logic [OPW-1:0] OP_ADD  = 4'h0;
  localparam logic [OPW-1:0] OP_SUB  = 4'h1;
  localparam logic [OPW-1:0] OP_AND  = 4'h2;
  localparam logic [OPW-1:0] OP_OR   = 4'h3;
  localparam logic [OPW-1:0] OP_XOR  = 4'h4;
  localparam logic [OPW-1:0] OP_ADDI = 4'h5;
  localparam logic [OPW-1:0] OP_LW   = 4'h6;
  localparam logic [OPW-1:0] OP_SW   = 4'h7;
  localparam logic [OPW-1:0] OP_BEQ  = 4'h8;
  localparam logic [OPW-1:0] OP_BNE  = 4'h9;
  localparam logic [OPW-1:0] OP_JMP  = 4'hA;
  localparam logic [OPW-1:0] OP_NOP  = 4'hF;

  localparam logic [ISIZE-1:0] NOP_INST = 18'h3C000;

  typedef enum logic [ALUW-1:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4
  } aluop_e;

  // ID/EX pipeline payload
  typedef struct packed {
    logic [DSIZE-1:0] rdata1;
    logic [DSIZE-1:0] rdata2;
    logic [DSIZE-1:0] imm;
    logic [RSIZE-1:0] rs1;
    logic [RSIZE-1:0] rs2;
    logic [RSIZE-1:0] rd;
    logic [ALUW-1:0]  aluop;
    logic             alusrc;
    logic             regwrite;
    logic             memread;
    logic             memwrite;
  } idex_t;

  // Sign-extend the 8-bit immediate to datapath width
  function automatic logic [DSIZE-1:0] sext_imm8(input logic [IMM_W-1:0] v);
    return {{(DSIZE-IMM_W){v[IMM_W-1]}}, v};
  endfunction

endpackage

// File: rtl/up16_regfile.sv
// uP16 register file: 8x16, two combinational read ports with write-through, R0 hardwired to 0.
module up16_regfile
  import up16_pkg::*;
(
  input  logic             Clk,
  input  logic             Rst,
  input  logic [RSIZE-1:0] raddr1,
  input  logic [RSIZE-1:0] raddr2,
  output logic [DSIZE-1:0] rdata1_c,
  output logic [DSIZE-1:0] rdata2_c,
  input  logic             we,
  input  logic [RSIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata
);

  logic [DSIZE-1:0] regs_q [NREGS];
  logic [DSIZE-1:0] regs_d [NREGS];
  logic             wr_en;

  assign wr_en = we && (waddr != '0);

  // Next register contents: single write port, R0 never written
  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[waddr] = wdata;
  end

  // Register array state
  always_ff @(posedge Clk) begin
    if (Rst) regs_q <= '{default: '0};
    else     regs_q <= regs_d;
  end

  // Read port 1 with same-cycle write bypass
  always_comb begin
    rdata1_c = regs_q[raddr1];
    if (raddr1 == '0)                     rdata1_c = '0;
    else if (wr_en && (waddr == raddr1))  rdata1_c = wdata;
  end

  // Read port 2 with same-cycle write bypass
  always_comb begin
    rdata2_c = regs_q[raddr2];
    if (raddr2 == '0)                     rdata2_c = '0;
    else if (wr_en && (waddr == raddr2))  rdata2_c = wdata;
  end

endmodule

// File: rtl/id_stage.sv
// uP16 decode stage: IF/ID register, register file, decoder, hazard detection,
// branch/jump resolution and the ID/EX register.
module id_stage
  import up16_pkg::*;
(
  input  logic             Clk,
  input  logic             Rst,
  input  logic [ISIZE-1:0] if_inst,
  input  logic [DSIZE-1:0] if_PCplus1,
  output logic             sel_PC,
  output logic [DSIZE-1:0] alt_PC,
  input  logic [RSIZE-1:0] ex_rd,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [RSIZE-1:0] mem_rd,
  input  logic             mem_regwrite,
  input  logic             wb_we,
  input  logic [RSIZE-1:0] wb_addr,
  input  logic [DSIZE-1:0] wb_data,
  output logic [DSIZE-1:0] id_rdata1,
  output logic [DSIZE-1:0] id_rdata2,
  output logic [DSIZE-1:0] id_imm,
  output logic [RSIZE-1:0] id_rs1,
  output logic [RSIZE-1:0] id_rs2,
  output logic [RSIZE-1:0] id_rd,
  output logic [ALUW-1:0]  id_aluop,
  output logic             id_alusrc,
  output logic             id_regwrite,
  output logic             id_memread,
  output logic             id_memwrite,
  output logic             stall
);

  logic [ISIZE-1:0] ifid_inst_q, ifid_inst_d;
  logic [DSIZE-1:0] ifid_pcp1_q, ifid_pcp1_d;
  idex_t            idex_q, idex_d;

  logic [OPW-1:0]   opcode;
  logic [RSIZE-1:0] rd_f, rs1_f, rs2_f, raddr2;
  logic [IMM_W-1:0] imm8;
  logic             use1, use2, is_beq, is_bne, is_jmp;
  logic             dec_regwrite, dec_memread, dec_memwrite, dec_alusrc;
  logic [ALUW-1:0]  dec_aluop;
  logic [DSIZE-1:0] rf_rdata1, rf_rdata2;
  logic             load_use, br_hazard, hazard, taken, redirect;

  assign opcode = ifid_inst_q[OP_LSB  +: OPW];
  assign rd_f   = ifid_inst_q[RD_LSB  +: RSIZE];
  assign rs1_f  = ifid_inst_q[RS1_LSB +: RSIZE];
  assign rs2_f  = ifid_inst_q[RS2_LSB +: RSIZE];
  assign imm8   = ifid_inst_q[IMM_W-1:0];

  up16_regfile u_regfile (
    .Clk      (Clk),
    .Rst      (Rst),
    .raddr1   (rs1_f),
    .raddr2   (raddr2),
    .rdata1_c (rf_rdata1),
    .rdata2_c (rf_rdata2),
    .we       (wb_we),
    .waddr    (wb_addr),
    .wdata    (wb_data)
  );

  // Decode the held instruction; SW/BEQ/BNE read rd through port 2
  always_comb begin
    use1         = 1'b0;
    use2         = 1'b0;
    raddr2       = rs2_f;
    is_beq       = 1'b0;
    is_bne       = 1'b0;
    is_jmp       = 1'b0;
    dec_aluop    = ALU_ADD;
    dec_alusrc   = 1'b0;
    dec_regwrite = 1'b0;
    dec_memread  = 1'b0;
    dec_memwrite = 1'b0;
    case (opcode)
      OP_ADD:  begin use1 = 1'b1; use2 = 1'b1; dec_regwrite = 1'b1; dec_aluop = ALU_ADD; end
      OP_SUB:  begin use1 = 1'b1; use2 = 1'b1; dec_regwrite = 1'b1; dec_aluop = ALU_SUB; end
      OP_AND:  begin use1 = 1'b1; use2 = 1'b1; dec_regwrite = 1'b1; dec_aluop = ALU_AND; end
      OP_OR:   begin use1 = 1'b1; use2 = 1'b1; dec_regwrite = 1'b1; dec_aluop = ALU_OR;  end
      OP_XOR:  begin use1 = 1'b1; use2 = 1'b1; dec_regwrite = 1'b1; dec_aluop = ALU_XOR; end
      OP_ADDI: begin use1 = 1'b1; dec_alusrc = 1'b1; dec_regwrite = 1'b1; end
      OP_LW:   begin use1 = 1'b1; dec_alusrc = 1'b1; dec_regwrite = 1'b1; dec_memread = 1'b1; end
      OP_SW:   begin use1 = 1'b1; use2 = 1'b1; raddr2 = rd_f; dec_alusrc = 1'b1; dec_memwrite = 1'b1; end
      OP_BEQ:  begin use1 = 1'b1; use2 = 1'b1; raddr2 = rd_f; is_beq = 1'b1; end
      OP_BNE:  begin use1 = 1'b1; use2 = 1'b1; raddr2 = rd_f; is_bne = 1'b1; end
      OP_JMP:  begin is_jmp = 1'b1; end
      OP_NOP:  begin end
      default: begin end
    endcase
  end

  // Load-use and branch-operand hazards; R0 never matches
  always_comb begin
    load_use  = ex_memread && (ex_rd != '0) &&
                ((use1 && (ex_rd == rs1_f)) || (use2 && (ex_rd == raddr2)));
    br_hazard = (is_beq || is_bne) &&
                ((ex_regwrite  && (ex_rd  != '0) && ((ex_rd  == rs1_f) || (ex_rd  == raddr2))) ||
                 (mem_regwrite && (mem_rd != '0) && ((mem_rd == rs1_f) || (mem_rd == raddr2))));
    hazard    = load_use || br_hazard;
  end

  // Branch/jump resolution and fetch redirect; reset wins over everything
  always_comb begin
    taken    = is_jmp || (is_beq && (rf_rdata1 == rf_rdata2)) ||
               (is_bne && (rf_rdata1 != rf_rdata2));
    redirect = !hazard && taken;
    stall    = !Rst && hazard;
    sel_PC   = !Rst && (hazard || redirect);
    alt_PC   = ifid_pcp1_q + sext_imm8(imm8);
    if (hazard)      alt_PC = if_PCplus1 - DSIZE'(1);
    else if (is_jmp) alt_PC = DSIZE'(ifid_inst_q[JMP_W-1:0]);
  end

  // IF/ID next state: hold on stall, flush to NOP on redirect
  always_comb begin
    ifid_inst_d = if_inst;
    ifid_pcp1_d = if_PCplus1;
    if (hazard) begin
      ifid_inst_d = ifid_inst_q;
      ifid_pcp1_d = ifid_pcp1_q;
    end else if (taken) begin
      ifid_inst_d = NOP_INST;
    end
  end

  // ID/EX next state: bubble on stall, branches and jumps carry nothing into EX
  always_comb begin
    idex_d = '0;
    if (!hazard && !(is_beq || is_bne || is_jmp)) begin
      idex_d.rdata1   = rf_rdata1;
      idex_d.rdata2   = rf_rdata2;
      idex_d.imm      = sext_imm8(imm8);
      idex_d.rs1      = use1 ? rs1_f : '0;
      idex_d.rs2      = use2 ? raddr2 : '0;
      idex_d.rd       = dec_regwrite ? rd_f : '0;
      idex_d.aluop    = dec_aluop;
      idex_d.alusrc   = dec_alusrc;
      idex_d.regwrite = dec_regwrite;
      idex_d.memread  = dec_memread;
      idex_d.memwrite = dec_memwrite;
    end
  end

  // Pipeline registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      ifid_inst_q <= NOP_INST;
      ifid_pcp1_q <= '0;
      idex_q      <= '0;
    end else begin
      ifid_inst_q <= ifid_inst_d;
      ifid_pcp1_q <= ifid_pcp1_d;
      idex_q      <= idex_d;
    end
  end

  assign id_rdata1   = idex_q.rdata1;
  assign id_rdata2   = idex_q.rdata2;
  assign id_imm      = idex_q.imm;
  assign id_rs1      = idex_q.rs1;
  assign id_rs2      = idex_q.rs2;
  assign id_rd       = idex_q.rd;
  assign id_aluop    = idex_q.aluop;
  assign id_alusrc   = idex_q.alusrc;
  assign id_regwrite = idex_q.regwrite;
  assign id_memread  = idex_q.memread;
  assign id_memwrite = idex_q.memwrite;

endmodule

// File: tb/tb_id_stage.sv
// Directed scoreboard bench for id_stage: each step queues the expected
// per-cycle response; a negedge monitor pops and compares.
module tb_id_stage;
  import up16_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [17:0] if_inst;
  logic [15:0] if_PCplus1;
  logic        sel_PC;
  logic [15:0] alt_PC;
  logic [2:0]  ex_rd, mem_rd, wb_addr;
  logic        ex_regwrite, ex_memread, mem_regwrite, wb_we;
  logic [15:0] wb_data;
  logic [15:0] id_rdata1, id_rdata2, id_imm;
  logic [2:0]  id_rs1, id_rs2, id_rd, id_aluop;
  logic        id_alusrc, id_regwrite, id_memread, id_memwrite, stall;

  always #5 Clk = ~Clk;

  id_stage dut (
    .Clk(Clk), .Rst(Rst), .if_inst(if_inst), .if_PCplus1(if_PCplus1),
    .sel_PC(sel_PC), .alt_PC(alt_PC),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_aluop(id_aluop),
    .id_alusrc(id_alusrc), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .stall(stall)
  );

  typedef struct packed {
    logic        cc;   // compare stall/sel_PC (and alt_PC when sel expected)
    logic        st;
    logic        sp;
    logic [15:0] ap;
    idex_t       ex;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_err    = 0;

  exp_t  mon_e;
  string mon_n;
  idex_t mon_a;

  function automatic idex_t mk(input logic [15:0] r1, input logic [15:0] r2,
                               input logic [15:0] imm, input logic [2:0] s1,
                               input logic [2:0] s2, input logic [2:0] d,
                               input logic [2:0] op, input logic asrc,
                               input logic rw, input logic mr, input logic mw);
    idex_t v;
    v.rdata1 = r1; v.rdata2 = r2; v.imm = imm;
    v.rs1 = s1; v.rs2 = s2; v.rd = d; v.aluop = op;
    v.alusrc = asrc; v.regwrite = rw; v.memread = mr; v.memwrite = mw;
    return v;
  endfunction

  // Drive one fetch cycle and queue what the DUT must show during it
  task automatic step(input logic [17:0] inst, input logic [15:0] pcp1,
                      input logic cc, input logic st, input logic sp,
                      input logic [15:0] ap, input idex_t ex, input string nm);
    exp_t e;
    if_inst    = inst;
    if_PCplus1 = pcp1;
    e.cc = cc; e.st = st; e.sp = sp; e.ap = ap; e.ex = ex;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge Clk);
    #1;
  endtask

  // Monitor: compare DUT outputs against the queued expectation
  always @(negedge Clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      mon_n = name_q.pop_front();
      mon_a.rdata1 = id_rdata1; mon_a.rdata2 = id_rdata2; mon_a.imm = id_imm;
      mon_a.rs1 = id_rs1; mon_a.rs2 = id_rs2; mon_a.rd = id_rd;
      mon_a.aluop = id_aluop; mon_a.alusrc = id_alusrc;
      mon_a.regwrite = id_regwrite; mon_a.memread = id_memread;
      mon_a.memwrite = id_memwrite;
      n_checks++;
      if (mon_a !== mon_e.ex) begin
        n_err++;
        $display("FAIL %s idex: got %h expected %h", mon_n, mon_a, mon_e.ex);
      end
      if (mon_e.cc) begin
        n_checks++;
        if (stall !== mon_e.st || sel_PC !== mon_e.sp) begin
          n_err++;
          $display("FAIL %s stall/sel_PC: got %b/%b expected %b/%b",
                   mon_n, stall, sel_PC, mon_e.st, mon_e.sp);
        end
        if (mon_e.sp) begin
          n_checks++;
          if (alt_PC !== mon_e.ap) begin
            n_err++;
            $display("FAIL %s alt_PC: got %h expected %h", mon_n, alt_PC, mon_e.ap);
          end
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  localparam logic [17:0] I_NOP   = 18'h3C000;
  localparam logic [17:0] I_ADDI  = 18'h151FD;  // ADDI R2,R1,#-3
  localparam logic [17:0] I_ADD4  = 18'h02320;  // ADD  R4,R3,R1
  localparam logic [17:0] I_BEQ1  = 18'h20904;  // BEQ  R1,R1,#+4
  localparam logic [17:0] I_ADD5  = 18'h02920;  // ADD  R5,R1,R1 (wrong path)
  localparam logic [17:0] I_BNE2  = 18'h25210;  // BNE  R2,R2,#+16
  localparam logic [17:0] I_XOR5  = 18'h12920;  // XOR  R5,R1,R1
  localparam logic [17:0] I_JMP   = 18'h2BFF0;  // JMP  0x3FF0
  localparam logic [17:0] I_SW    = 18'h1CA05;  // SW   R1,[R2+5]
  localparam logic [17:0] I_BEQ6  = 18'h20E02;  // BEQ  R6,R1,#+2
  localparam logic [17:0] I_ADD7  = 18'h03920;  // ADD  R7,R1,R1

  initial begin
    idex_t z, e_addi, e_add4, e_xor5, e_sw, e_add7;
    z      = '0;
    e_addi = mk(16'h0005, 16'h0000, 16'hFFFD, 3'd1, 3'd0, 3'd2, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    e_add4 = mk(16'h1234, 16'h0005, 16'h0020, 3'd3, 3'd1, 3'd4, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    e_xor5 = mk(16'h0005, 16'h0005, 16'h0020, 3'd1, 3'd1, 3'd5, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0);
    e_sw   = mk(16'h0000, 16'h0005, 16'h0005, 3'd2, 3'd1, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    e_add7 = mk(16'h0000, 16'h0000, 16'h0020, 3'd1, 3'd1, 3'd7, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    Rst = 1'b1; if_inst = I_NOP; if_PCplus1 = '0;
    ex_rd = '0; ex_regwrite = 1'b0; ex_memread = 1'b0;
    mem_rd = '0; mem_regwrite = 1'b0;
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    @(posedge Clk); #1;

    // Reset and NOP stream
    step(I_NOP, 16'h0000, 1, 0, 0, 16'h0, z, "reset0");
    step(I_NOP, 16'h0000, 1, 0, 0, 16'h0, z, "reset1");
    Rst = 1'b0;
    step(I_NOP, 16'h0000, 1, 0, 0, 16'h0, z, "nop0");
    step(I_NOP, 16'h0000, 1, 0, 0, 16'h0, z, "nop1");

    // ADDI reading R1 in the same cycle it is written back
    step(I_ADDI, 16'h0001, 1, 0, 0, 16'h0, z, "addi_fetch");
    wb_we = 1'b1; wb_addr = 3'd1; wb_data = 16'h0005;
    step(I_NOP, 16'h0002, 1, 0, 0, 16'h0, z, "addi_decode");
    wb_we = 1'b0;
    step(I_ADD4, 16'h0010, 1, 0, 0, 16'h0, e_addi, "addi_out");

    // Load-use stall with an unrelated write-back of R3 in the same cycle
    ex_memread = 1'b1; ex_rd = 3'd3;
    wb_we = 1'b1; wb_addr = 3'd3; wb_data = 16'h1234;
    step(I_NOP, 16'h0011, 1, 1, 1, 16'h0010, z, "lu_stall");
    ex_memread = 1'b0; ex_rd = '0; wb_we = 1'b0;
    step(I_NOP, 16'h0011, 1, 0, 0, 16'h0, z, "lu_bubble");
    step(I_NOP, 16'h0012, 1, 0, 0, 16'h0, e_add4, "lu_issue");

    // Taken BEQ flushes the wrong-path fetch
    step(I_BEQ1, 16'h0008, 1, 0, 0, 16'h0, z, "beq_fetch");
    step(I_ADD5, 16'h0009, 1, 0, 1, 16'h000C, z, "beq_taken");
    step(I_NOP, 16'h000D, 1, 0, 0, 16'h0, z, "beq_flush");

    // Not-taken BNE keeps the following instruction
    step(I_BNE2, 16'h0020, 1, 0, 0, 16'h0, z, "bne_fetch");
    step(I_XOR5, 16'h0021, 1, 0, 0, 16'h0, z, "bne_nt");
    step(I_NOP, 16'h0022, 1, 0, 0, 16'h0, z, "bne_noctl");

    // JMP redirect, then a store
    step(I_JMP, 16'h0023, 1, 0, 0, 16'h0, e_xor5, "xor_out");
    step(I_ADD5, 16'h0024, 1, 0, 1, 16'h3FF0, z, "jmp_taken");
    step(I_SW, 16'h3FF1, 1, 0, 0, 16'h0, z, "jmp_flush");
    step(I_NOP, 16'h3FF2, 1, 0, 0, 16'h0, z, "sw_decode");

    // Branch operand hazard from MEM, resolved with the written-back value
    step(I_BEQ6, 16'h0030, 1, 0, 0, 16'h0, e_sw, "sw_out");
    mem_regwrite = 1'b1; mem_rd = 3'd6;
    step(I_NOP, 16'h0031, 1, 1, 1, 16'h0030, z, "brh_stall");
    mem_regwrite = 1'b0; mem_rd = '0;
    wb_we = 1'b1; wb_addr = 3'd6; wb_data = 16'h0005;
    step(I_NOP, 16'h0031, 1, 0, 1, 16'h0032, z, "brh_taken");
    wb_we = 1'b0;

    // Reset during a stall clears the pipeline and register file
    step(I_ADDI, 16'h003F, 1, 0, 0, 16'h0, z, "rst_pre0");
    step(I_BEQ6, 16'h0040, 1, 0, 0, 16'h0, z, "rst_pre1");
    ex_regwrite = 1'b1; ex_rd = 3'd1;
    step(I_NOP, 16'h0041, 1, 1, 1, 16'h0040, e_addi, "rst_stall");
    Rst = 1'b1;
    step(I_NOP, 16'h0041, 0, 0, 0, 16'h0, z, "rst_assert");
    Rst = 1'b0;
    step(I_ADD7, 16'h0050, 1, 0, 0, 16'h0, z, "rst_cleared");
    ex_regwrite = 1'b0; ex_rd = '0;
    step(I_NOP, 16'h0051, 1, 0, 0, 16'h0, z, "rst_add7");
    step(I_NOP, 16'h0052, 1, 0, 0, 16'h0, e_add7, "rst_regs0");

    repeat (2) @(posedge Clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
